// File: rtl/msxbus_pkg.sv
// Shared definitions for the MSX bus arbiter: command codes, FSM states,
// default bus_done wait limit and command-decode helpers.
package msxbus_pkg;

   localparam logic [2:0] CMD_MEM_RD = 3'd1;
   localparam logic [2:0] CMD_MEM_WR = 3'd2;
   localparam logic [2:0] CMD_IO_RD  = 3'd3;
   localparam logic [2:0] CMD_IO_WR  = 3'd4;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   function automatic logic cmd_is_valid(input logic [2:0] cmd);
      return (cmd == CMD_MEM_RD) || (cmd == CMD_MEM_WR) ||
             (cmd == CMD_IO_RD)  || (cmd == CMD_IO_WR);
   endfunction

   function automatic logic cmd_is_read(input logic [2:0] cmd);
      return (cmd == CMD_MEM_RD) || (cmd == CMD_IO_RD);
   endfunction

endpackage

// File: rtl/msxbus_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// whichever requester was not served last.
module msxbus_rr_pick (
   input  logic [1:0] req,
   input  logic       last_served,
   output logic       grant_valid,
   output logic       grant_sel
);

   always_comb begin
      grant_valid = |req;
      if (req == 2'b11) begin
         grant_sel = ~last_served;
      end else begin
         grant_sel = req[1];
      end
   end

endmodule

// File: rtl/msxbus_arbiter.sv
// MSX bus arbiter: SPI host and secondary master share one Z80 cycle engine.
// Optional bus_done watchdog enabled by defining MSXBUS_ARB_TIMEOUT_EN.
module msxbus_arbiter
   import msxbus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [2:0]  cmd0,
   input  logic [2:0]  cmd1,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [7:0]  wdata0,
   input  logic [7:0]  wdata1,
   output logic [1:0]  ack,
   output logic [7:0]  rdata,
   output logic        err,
   output logic        busy,
   output logic        bus_start,
   output logic [2:0]  bus_cmd,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic        bus_done,
   input  logic [7:0]  bus_rdata,
   output logic        bus_abort
);

   arb_state_t state;
   logic       sel;
   logic       last_served;
   logic       pick_valid;
   logic       pick_sel;
   logic       cmd_valid;
   logic       timeout_hit;

   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("msxbus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
   end

   msxbus_rr_pick u_rr_pick (
      .req         (req),
      .last_served (last_served),
      .grant_valid (pick_valid),
      .grant_sel   (pick_sel)
   );

   // Strobes decode straight from the registered state so each lasts one state.
   assign cmd_valid = cmd_is_valid(bus_cmd);
   assign busy      = (state != ST_IDLE);
   assign bus_start = (state == ST_ISSUE) && cmd_valid;
   assign ack       = (state == ST_DONE) ? (sel ? 2'b10 : 2'b01) : 2'b00;

`ifdef MSXBUS_ARB_TIMEOUT_EN
   logic [15:0] wait_cnt;

   // A bus_done arriving on the final wait cycle still wins over the abort.
   assign timeout_hit = (state == ST_WAIT) && !bus_done &&
                        (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign bus_abort   = timeout_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == ST_ISSUE) begin
         wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_abort   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         sel         <= 1'b0;
         last_served <= 1'b1;
         err         <= 1'b0;
         rdata       <= '1;
         bus_cmd     <= '0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  sel       <= pick_sel;
                  bus_cmd   <= pick_sel ? cmd1   : cmd0;
                  bus_addr  <= pick_sel ? addr1  : addr0;
                  bus_wdata <= pick_sel ? wdata1 : wdata0;
                  err       <= 1'b0;
                  rdata     <= '1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (cmd_valid) begin
                  state <= ST_WAIT;
               end else begin
                  err   <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_WAIT: begin
               if (bus_done) begin
                  rdata <= cmd_is_read(bus_cmd) ? bus_rdata : 8'hFF;
                  state <= ST_DONE;
               end else if (timeout_hit) begin
                  err   <= 1'b1;
                  rdata <= 8'hFF;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               last_served <= sel;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msxbus_arbiter.sv
// Self-checking bench for msxbus_arbiter: timeline reference model plus
// directed scenarios; watchdog cases run when MSXBUS_ARB_TIMEOUT_EN is defined.
module tb_msxbus_arbiter;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [2:0]  cmd0, cmd1;
   logic [15:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic [1:0]  ack;
   logic [7:0]  rdata;
   logic        err, busy, bus_start, bus_abort, bus_done;
   logic [2:0]  bus_cmd;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata, bus_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   msxbus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .cmd0(cmd0), .cmd1(cmd1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack(ack), .rdata(rdata), .err(err), .busy(busy),
      .bus_start(bus_start), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_done(bus_done), .bus_rdata(bus_rdata),
      .bus_abort(bus_abort)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [2:0] c);
      return (c >= 3'd1) && (c <= 3'd4);
   endfunction

   function automatic bit rd_cmd(input logic [2:0] c);
      return (c == 3'd1) || (c == 3'd3);
   endfunction

   // Reference model: one transaction record, timed by its age since grant.
   bit          m_active = 1'b0;
   bit          m_who    = 1'b0;
   bit          m_last   = 1'b1;
   bit          m_err    = 1'b0;
   logic [2:0]  m_cmd    = '0;
   logic [15:0] m_addr   = '0;
   logic [7:0]  m_wdata  = '0;
   logic [7:0]  m_rdata  = 8'hFF;
   int          m_age    = 0;
   int          m_ack_age = -1;

   always @(negedge clk) begin : compare
      logic [1:0] exp_ack;
      logic       exp_abort;
      logic       v;
      if (!rst_n) begin
         check("rst_ack", ack, 2'b00);
         check("rst_busy", busy, 1'b0);
         check("rst_start", bus_start, 1'b0);
         check("rst_abort", bus_abort, 1'b0);
         check("rst_err", err, 1'b0);
         check("rst_rdata", rdata, 8'hFF);
         check("rst_cmd", bus_cmd, 3'd0);
         check("rst_addr", bus_addr, 16'd0);
         check("rst_wdata", bus_wdata, 8'd0);
         m_active = 1'b0;
         m_last   = 1'b1;
         m_cmd    = '0;
         m_addr   = '0;
         m_wdata  = '0;
      end else begin
         v         = legal(m_cmd);
         exp_ack   = (m_active && m_age == m_ack_age) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
         exp_abort = 1'b0;
`ifdef MSXBUS_ARB_TIMEOUT_EN
         exp_abort = m_active && v && (m_ack_age < 0) && (m_age == T) && !bus_done;
`endif
         check("busy", busy, m_active);
         check("bus_start", bus_start, m_active && v && (m_age == 0));
         check("bus_abort", bus_abort, exp_abort);
         check("ack", ack, exp_ack);
         check("bus_cmd", bus_cmd, m_cmd);
         check("bus_addr", bus_addr, m_addr);
         check("bus_wdata", bus_wdata, m_wdata);
         if (exp_ack != 2'b00) begin
            check("err", err, m_err);
            if (v) check("rdata", rdata, m_rdata);
         end
         if (m_active) begin
            if (m_age == m_ack_age) begin
               m_active = 1'b0;
               m_last   = m_who;
            end else begin
               if (v && m_ack_age < 0 && m_age >= 1 && bus_done) begin
                  m_ack_age = m_age + 1;
                  m_err     = 1'b0;
                  m_rdata   = rd_cmd(m_cmd) ? bus_rdata : 8'hFF;
               end else if (exp_abort) begin
                  m_ack_age = m_age + 1;
                  m_err     = 1'b1;
                  m_rdata   = 8'hFF;
               end
               m_age++;
            end
         end else if (req != 2'b00) begin
            m_who     = (req == 2'b11) ? !m_last : req[1];
            m_cmd     = m_who ? cmd1 : cmd0;
            m_addr    = m_who ? addr1 : addr0;
            m_wdata   = m_who ? wdata1 : wdata0;
            m_active  = 1'b1;
            m_age     = 0;
            m_err     = !legal(m_cmd);
            m_ack_age = legal(m_cmd) ? -1 : 1;
         end
      end
   end

   // Cycle-engine responder: answers bus_start with bus_done after a delay.
   bit       engine_en    = 1'b1;
   int       eng_delay    = 0;
   bit       eng_rd_force = 1'b0;
   logic [7:0] eng_rd_val = 8'h00;
   int       eng_cnt      = -1;

   initial begin
      bus_done  = 1'b0;
      bus_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #3;
         bus_done  = 1'b0;
         bus_rdata = 8'($urandom);
         if (!rst_n) begin
            eng_cnt = -1;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               bus_done = 1'b1;
               if (eng_rd_force) bus_rdata = eng_rd_val;
               eng_cnt = -1;
            end
         end else if (bus_start && engine_en) begin
            eng_cnt = (eng_delay > 0) ? eng_delay : int'($urandom_range(1, 6));
         end
      end
   end

   task automatic to_drive();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ack(input int budget, output logic [1:0] a, output logic e,
                           output logic [7:0] rd, output int n, output int starts,
                           output int aborts);
      a = 2'b00; e = 1'b0; rd = 8'h00; n = 0; starts = 0; aborts = 0;
      while (n < budget) begin
         @(negedge clk);
         #1;
         n++;
         if (bus_start) starts++;
         if (bus_abort) aborts++;
         if (ack != 2'b00) begin
            a  = ack;
            e  = err;
            rd = rdata;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL ack_wait: no ack within %0d cycles at %0t", budget, $time);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin : stim
      logic [1:0] a;
      logic       e;
      logic [7:0] rd;
      int         n, st, ab;
      bit         order_exp [4];
      order_exp = '{1'b0, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; req = 2'b00;
      cmd0 = 3'd0; cmd1 = 3'd0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) to_drive();

      // Single mem read from requester 0, bus_done two cycles after bus_start.
      eng_delay = 2; eng_rd_force = 1'b1; eng_rd_val = 8'hA5;
      req = 2'b01; cmd0 = 3'd1; addr0 = 16'h4000; wdata0 = 8'h3C;
      wait_ack(20, a, e, rd, n, st, ab);
      req = 2'b00;
      check("d34_ack", a, 2'b01);
      check("d34_rdata", rd, 8'hA5);
      check("d34_err", e, 1'b0);
      check("d34_latency", n, 5);
      eng_rd_force = 1'b0; eng_delay = 0;

      // Invalid command from requester 1: no bus_start, error ack.
      to_drive();
      req = 2'b10; cmd1 = 3'd0; addr1 = 16'h8123;
      wait_ack(20, a, e, rd, n, st, ab);
      req = 2'b00;
      check("d36_ack", a, 2'b10);
      check("d36_err", e, 1'b1);
      check("d36_starts", st, 0);
      check("d36_latency", n, 3);

      // Both requesting continuously: strict alternation starting at 0.
      to_drive();
      req = 2'b11; cmd0 = 3'd2; addr0 = 16'h1234; wdata0 = 8'h55;
      cmd1 = 3'd3; addr1 = 16'h00A8; wdata1 = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         wait_ack(20, a, e, rd, n, st, ab);
         check("d35_grant", a[1], order_exp[i]);
         check("d35_onehot", a[0] ^ a[1], 1'b1);
      end
      req = 2'b00;

`ifdef MSXBUS_ARB_TIMEOUT_EN
      // No bus_done: watchdog aborts and the transaction is acked with err.
      to_drive();
      engine_en = 1'b0;
      req = 2'b01; cmd0 = 3'd3; addr0 = 16'h0099;
      wait_ack(40, a, e, rd, n, st, ab);
      req = 2'b00;
      check("d37_ack", a, 2'b01);
      check("d37_err", e, 1'b1);
      check("d37_rdata", rd, 8'hFF);
      check("d37_aborts", ab, 1);
      check("d37_latency", n, T + 3);
      engine_en = 1'b1;
`endif

      // Reset while waiting on the cycle engine, then a normal transaction.
      to_drive();
      eng_delay = 5;
      req = 2'b01; cmd0 = 3'd1; addr0 = 16'hC000;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!bus_start && n < 20);
      check("d38_started", bus_start, 1'b1);
      req = 2'b00;
      to_drive();
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("d38_busy_in_rst", busy, 1'b0);
      check("d38_ack_in_rst", ack, 2'b00);
      to_drive();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         check("d38_no_ack", ack, 2'b00);
         check("d38_no_abort", bus_abort, 1'b0);
      end
      eng_delay = 0;
      to_drive();
      req = 2'b10; cmd1 = 3'd4; addr1 = 16'h0077; wdata1 = 8'h19;
      wait_ack(20, a, e, rd, n, st, ab);
      req = 2'b00;
      check("d38_next_ack", a, 2'b10);
      check("d38_next_err", e, 1'b0);
      check("d38_next_rdata", rd, 8'hFF);

      // Random traffic with occasional asynchronous reset pulses.
      for (int c = 0; c < 600; c++) begin
         to_drive();
         rst_n  = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
         req    = 2'($urandom_range(0, 3));
         cmd0   = 3'($urandom_range(0, 7));
         cmd1   = 3'($urandom_range(0, 7));
         addr0  = 16'($urandom);
         addr1  = 16'($urandom);
         wdata0 = 8'($urandom);
         wdata1 = 8'($urandom);
      end
      to_drive();
      rst_n = 1'b1;
      req   = 2'b00;
      repeat (15) to_drive();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/msxbus_arbiter.md
MSXBUS_ARBITER -- requirements
Module: msxbus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: bus_done wait limit in clk cycles (range 2..65535).
REQ-002 SHALL have port clk  in  1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port req  in  2: per-requester request; bit0 = SPI host, bit1 = secondary master.
REQ-005 SHALL have ports cmd0, cmd1  in  3 each: requester bus command.
REQ-006 SHALL have ports addr0, addr1  in  16 each: requester Z80 address.
REQ-007 SHALL have ports wdata0, wdata1  in  8 each: requester write data.
REQ-008 SHALL have port ack  out  2: one-cycle completion pulse per requester.
REQ-009 SHALL have port rdata  out  8: read result, valid while any ack bit is 1.
REQ-010 SHALL have port err  out  1: error flag, valid while any ack bit is 1.
REQ-011 SHALL have port busy  out  1: high whenever the state is not IDLE.
REQ-012 SHALL have ports bus_start  out  1, bus_cmd  out  3, bus_addr  out  16, bus_wdata  out  8: cycle-engine request.
REQ-013 SHALL have ports bus_done  in  1, bus_rdata  in  8: cycle-engine completion and read data.
REQ-014 SHALL have port bus_abort  out  1: one-cycle pulse forcing the cycle engine back to idle.

Function
REQ-015 SHALL use command encoding 1 = mem read, 2 = mem write, 3 = IO read, 4 = IO write; 0 and 5..7 are invalid.
REQ-016 SHALL implement a state machine with states IDLE, ISSUE, WAIT, DONE.
REQ-017 In IDLE with req != 0, SHALL select one requester, latch its cmd/addr/wdata into bus_cmd/bus_addr/bus_wdata, and go to ISSUE.
REQ-018 With both req bits high, SHALL select the requester not recorded as last served (round-robin).
REQ-019 In ISSUE with a valid command, SHALL pulse bus_start for exactly one cycle and go to WAIT.
REQ-020 In ISSUE with an invalid command, SHALL NOT assert bus_start, SHALL set err=1, and SHALL go directly to DONE.
REQ-021 In WAIT, when bus_done=1, SHALL capture bus_rdata into rdata for read commands (rdata = 8'hFF for writes) and go to DONE.
REQ-022 In DONE, SHALL pulse ack[sel] for one cycle, update last-served to sel, and return to IDLE.
REQ-023 SHALL produce ack exactly one cycle after bus_done is seen in WAIT; minimum latency from req sampled in IDLE to ack is 3 cycles.
REQ-024 SHALL ignore req deassertion after latching; the latched transaction completes and is acked.
REQ-025 A req bit still high in the cycle after its ack SHALL be treated as a new request.
REQ-026 bus_cmd, bus_addr and bus_wdata SHALL hold stable from ISSUE through DONE.

Reset
REQ-027 While rst_n=0, SHALL force state IDLE, ack=0, bus_start=0, bus_abort=0, busy=0, err=0, rdata=8'hFF, bus_cmd=0, bus_addr=0, bus_wdata=0, last-served=1.
REQ-028 Reset asserted mid-transaction SHALL drop the transaction without ack and without bus_abort.

Configuration
REQ-029 With MSXBUS_ARB_TIMEOUT_EN defined, SHALL reset a wait counter in ISSUE and increment it each cycle in WAIT.
REQ-030 With MSXBUS_ARB_TIMEOUT_EN defined, if the wait counter reaches TIMEOUT_CYCLES-1 without bus_done, SHALL pulse bus_abort, set err=1 and rdata=8'hFF, and go to DONE.
REQ-031 With MSXBUS_ARB_TIMEOUT_EN undefined, SHALL wait in WAIT indefinitely, tie bus_abort to 0, and omit the counter.

Structure
REQ-032 SHALL take command encodings, the state enum and the default TIMEOUT_CYCLES from shared package msxbus_pkg.
REQ-033 SHALL place the 2-way round-robin selection in sub-module msxbus_rr_pick.

Verification
REQ-034 Bench SHALL check: req=01, cmd0=1, addr0=16'h4000, bus_done with bus_rdata=8'hA5 two cycles after bus_start -> ack=01, rdata=8'hA5, err=0.
REQ-035 Bench SHALL check: req=11 held for four transactions -> grants in order 0, 1, 0, 1.
REQ-036 Bench SHALL check: req=10, cmd1=0 -> no bus_start, then ack=10 with err=1.
REQ-037 Bench SHALL check: with MSXBUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no bus_done -> bus_abort pulse, then ack with err=1 and rdata=8'hFF.
REQ-038 Bench SHALL check: rst_n pulsed low while in WAIT -> busy=0 and no ack, and the next request proceeds normally.
